// File: rtl/afe2256_sample_assembler.sv
// Packs the AFE2256 nibble stream (MSB nibble first) into framed samples, with misalign/short-frame error counters and a frame lock flag.
// Latency: sample strobe one cycle after its last nibble. Flow control: nib_valid gaps stall, no backpressure.
module afe2256_sample_assembler #(
  parameter int SAMPLE_BITS       = 12,
  parameter int SAMPLES_PER_FRAME = 256,
  parameter int CNT_W             = 8,
  localparam int IDX_W            = $clog2(SAMPLES_PER_FRAME)
) (
  input  logic                   clkdiv,
  input  logic                   rst,
  input  logic                   enable,
  input  logic [3:0]             nib_in,
  input  logic                   nib_valid,
  input  logic                   frame_sync,
  input  logic                   err_clr,
  output logic [SAMPLE_BITS-1:0] sample_out,
  output logic                   sample_valid,
  output logic [IDX_W-1:0]       sample_idx,
  output logic                   sample_first,
  output logic                   sample_last,
  output logic                   frame_done,
  output logic                   locked,
  output logic [CNT_W-1:0]       err_misalign_cnt,
  output logic [CNT_W-1:0]       err_short_cnt
);

  localparam int NPS   = SAMPLE_BITS / 4;
  localparam int NIB_W = $clog2(NPS);
  localparam int SH_W  = SAMPLE_BITS - 4;

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] WAIT_SYNC = 2'd1;
  localparam logic [1:0] ASSEMBLE  = 2'd2;

  logic [1:0]       state;
  // Holds the NPS-1 nibbles received so far; the final nibble goes straight to sample_out.
  logic [SH_W-1:0]  shreg;
  logic [NIB_W-1:0] nib_cnt;
  logic [IDX_W-1:0] samp_cnt;

  logic accept;
  logic nib_last;
  logic samp_last;
  logic misalign_evt;
  logic short_evt;

  assign accept       = nib_valid & enable;
  assign nib_last     = (nib_cnt == NIB_W'(NPS - 1));
  assign samp_last    = (samp_cnt == IDX_W'(SAMPLES_PER_FRAME - 1));
  assign misalign_evt = (state == ASSEMBLE) & accept & frame_sync & (nib_cnt != '0);
  assign short_evt    = (state == ASSEMBLE) & accept & frame_sync & (nib_cnt == '0);

  always_ff @(posedge clkdiv or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      shreg        <= '0;
      nib_cnt      <= '0;
      samp_cnt     <= '0;
      sample_out   <= '0;
      sample_valid <= 1'b0;
      sample_idx   <= '0;
      sample_first <= 1'b0;
      sample_last  <= 1'b0;
      frame_done   <= 1'b0;
      locked       <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      sample_first <= 1'b0;
      sample_last  <= 1'b0;
      frame_done   <= 1'b0;
      if (!enable) begin
        state    <= IDLE;
        shreg    <= '0;
        nib_cnt  <= '0;
        samp_cnt <= '0;
        locked   <= 1'b0;
      end else begin
        case (state)
          IDLE: state <= WAIT_SYNC;
          WAIT_SYNC: begin
            if (accept && frame_sync) begin
              shreg    <= SH_W'(nib_in);
              nib_cnt  <= NIB_W'(1);
              samp_cnt <= '0;
              state    <= ASSEMBLE;
            end
          end
          ASSEMBLE: begin
            if (accept) begin
              if (frame_sync) begin
                // Early sync: drop the partial sample and restart the frame on this nibble.
                shreg    <= SH_W'(nib_in);
                nib_cnt  <= NIB_W'(1);
                samp_cnt <= '0;
                locked   <= 1'b0;
              end else if (nib_last) begin
                sample_out   <= {shreg, nib_in};
                sample_valid <= 1'b1;
                sample_idx   <= samp_cnt;
                sample_first <= (samp_cnt == '0);
                sample_last  <= samp_last;
                frame_done   <= samp_last;
                nib_cnt      <= '0;
                if (samp_last) begin
                  samp_cnt <= '0;
                  locked   <= 1'b1;
                  state    <= WAIT_SYNC;
                end else begin
                  samp_cnt <= samp_cnt + IDX_W'(1);
                end
              end else begin
                shreg   <= (shreg << 4) | SH_W'(nib_in);
                nib_cnt <= nib_cnt + NIB_W'(1);
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Error counters survive IDLE; err_clr beats a same-cycle increment.
  always_ff @(posedge clkdiv or posedge rst) begin
    if (rst) begin
      err_misalign_cnt <= '0;
      err_short_cnt    <= '0;
    end else if (err_clr) begin
      err_misalign_cnt <= '0;
      err_short_cnt    <= '0;
    end else begin
      if (misalign_evt && (err_misalign_cnt != '1))
        err_misalign_cnt <= err_misalign_cnt + CNT_W'(1);
      if (short_evt && (err_short_cnt != '1))
        err_short_cnt <= err_short_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_afe2256_sample_assembler.sv
// Directed bench for afe2256_sample_assembler: vector table for basic packing, hand sequences for framing, errors and saturation.
module tb_afe2256_sample_assembler;

  localparam int SB  = 12;
  localparam int SPF = 256;

  logic        clkdiv;
  logic        rst;
  logic        enable;
  logic [3:0]  nib_in;
  logic        nib_valid;
  logic        frame_sync;
  logic        err_clr;

  logic [SB-1:0] sample_out;
  logic          sample_valid;
  logic [7:0]    sample_idx;
  logic          sample_first;
  logic          sample_last;
  logic          frame_done;
  logic          locked;
  logic [7:0]    err_misalign_cnt;
  logic [7:0]    err_short_cnt;

  logic [SB-1:0] s2_sample_out;
  logic          s2_sample_valid;
  logic [7:0]    s2_sample_idx;
  logic          s2_sample_first;
  logic          s2_sample_last;
  logic          s2_frame_done;
  logic          s2_locked;
  logic [1:0]    s2_err_misalign_cnt;
  logic [1:0]    s2_err_short_cnt;

  afe2256_sample_assembler #(.SAMPLE_BITS(SB), .SAMPLES_PER_FRAME(SPF), .CNT_W(8)) u_dut (
    .clkdiv(clkdiv), .rst(rst), .enable(enable), .nib_in(nib_in), .nib_valid(nib_valid),
    .frame_sync(frame_sync), .err_clr(err_clr), .sample_out(sample_out), .sample_valid(sample_valid),
    .sample_idx(sample_idx), .sample_first(sample_first), .sample_last(sample_last),
    .frame_done(frame_done), .locked(locked), .err_misalign_cnt(err_misalign_cnt),
    .err_short_cnt(err_short_cnt)
  );

  // Narrow-counter copy sharing the same stimulus, used for saturation checks.
  afe2256_sample_assembler #(.SAMPLE_BITS(SB), .SAMPLES_PER_FRAME(SPF), .CNT_W(2)) u_sat (
    .clkdiv(clkdiv), .rst(rst), .enable(enable), .nib_in(nib_in), .nib_valid(nib_valid),
    .frame_sync(frame_sync), .err_clr(err_clr), .sample_out(s2_sample_out), .sample_valid(s2_sample_valid),
    .sample_idx(s2_sample_idx), .sample_first(s2_sample_first), .sample_last(s2_sample_last),
    .frame_done(s2_frame_done), .locked(s2_locked), .err_misalign_cnt(s2_err_misalign_cnt),
    .err_short_cnt(s2_err_short_cnt)
  );

  initial clkdiv = 1'b0;
  always #5 clkdiv = ~clkdiv;

  typedef struct {
    logic        en;
    logic        vld;
    logic        sync;
    logic [3:0]  nib;
    logic        exp_vld;
    logic [11:0] exp_smp;
    logic [7:0]  exp_idx;
    logic        exp_first;
  } vec_t;

  typedef struct {
    logic [7:0]  idx;
    logic [11:0] dat;
  } exp_t;

  vec_t vecs[10];
  exp_t exp_q[$];
  int   n_checks  = 0;
  int   n_fail    = 0;
  int   n_strobes = 0;
  bit   mon_en    = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  function automatic logic [11:0] samp_val(input int k);
    int v;
    v = (k * 173 + 29) & 12'hFFF;
    return v[11:0];
  endfunction

  task automatic tick();
    @(posedge clkdiv);
    #1;
  endtask

  task automatic send(input logic [3:0] n, input logic s, input int gap);
    nib_in     = n;
    frame_sync = s;
    nib_valid  = 1'b1;
    tick();
    nib_valid  = 1'b0;
    frame_sync = 1'b0;
    for (int g = 0; g < gap; g++) tick();
  endtask

  task automatic send_sample(input logic [11:0] v, input logic s, input int maxgap);
    send(v[11:8], s,    int'($urandom % (maxgap + 1)));
    send(v[7:4],  1'b0, int'($urandom % (maxgap + 1)));
    send(v[3:0],  1'b0, int'($urandom % (maxgap + 1)));
  endtask

  // Scoreboard: every strobe must match the head of the expected queue.
  always @(negedge clkdiv) begin : monitor
    exp_t e;
    if (mon_en && sample_valid === 1'b1) begin
      n_strobes++;
      check("strobe_expected", 32'(sample_valid), 32'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("strobe_idx", 32'(sample_idx), 32'(e.idx));
        check("strobe_data", 32'(sample_out), 32'(e.dat));
        check("strobe_first_last_done", {29'd0, sample_first, sample_last, frame_done},
              {29'd0, e.idx == 8'd0, e.idx == 8'(SPF - 1), e.idx == 8'(SPF - 1)});
      end
    end
  end

  initial begin
    int s0;
    vecs[0] = '{1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 12'h000, 8'd0, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 4'hF, 1'b0, 12'h000, 8'd0, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 1'b1, 4'hA, 1'b0, 12'h000, 8'd0, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 4'hB, 1'b0, 12'h000, 8'd0, 1'b0};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 4'hC, 1'b1, 12'hABC, 8'd0, 1'b1};
    vecs[5] = '{1'b1, 1'b1, 1'b0, 4'h1, 1'b0, 12'h000, 8'd0, 1'b0};
    vecs[6] = '{1'b1, 1'b0, 1'b1, 4'h7, 1'b0, 12'h000, 8'd0, 1'b0};
    vecs[7] = '{1'b1, 1'b1, 1'b0, 4'h2, 1'b0, 12'h000, 8'd0, 1'b0};
    vecs[8] = '{1'b1, 1'b1, 1'b0, 4'h3, 1'b1, 12'h123, 8'd1, 1'b0};
    vecs[9] = '{1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 12'h000, 8'd0, 1'b0};

    rst = 1'b1; enable = 1'b0; nib_in = 4'h0; nib_valid = 1'b0; frame_sync = 1'b0; err_clr = 1'b0;
    tick();
    tick();
    check("rst_sample_valid", 32'(sample_valid), 32'd0);
    check("rst_sample_out", 32'(sample_out), 32'd0);
    check("rst_sample_idx", 32'(sample_idx), 32'd0);
    check("rst_first_last_done", {29'd0, sample_first, sample_last, frame_done}, 32'd0);
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_err_misalign", 32'(err_misalign_cnt), 32'd0);
    check("rst_err_short", 32'(err_short_cnt), 32'd0);
    rst = 1'b0;
    tick();

    // Basic packing, stall and ignored sync during a gap.
    for (int i = 0; i < 10; i++) begin
      enable = vecs[i].en; nib_valid = vecs[i].vld; frame_sync = vecs[i].sync; nib_in = vecs[i].nib;
      tick();
      check($sformatf("vec%0d_valid", i), 32'(sample_valid), 32'(vecs[i].exp_vld));
      if (vecs[i].exp_vld) begin
        check($sformatf("vec%0d_data", i), 32'(sample_out), 32'(vecs[i].exp_smp));
        check($sformatf("vec%0d_idx", i), 32'(sample_idx), 32'(vecs[i].exp_idx));
        check($sformatf("vec%0d_first", i), 32'(sample_first), 32'(vecs[i].exp_first));
        check($sformatf("vec%0d_last", i), 32'(sample_last), 32'd0);
      end
    end
    nib_valid = 1'b0; frame_sync = 1'b0;

    // Full frame with random gaps.
    enable = 1'b0;
    tick();
    check("idle_locked", 32'(locked), 32'd0);
    enable = 1'b1;
    tick();
    mon_en = 1'b1;
    s0 = n_strobes;
    for (int k = 0; k < SPF; k++) begin
      exp_q.push_back('{8'(k), samp_val(k)});
      send_sample(samp_val(k), k == 0, 2);
    end
    tick();
    tick();
    check("frame_strobe_count", 32'(n_strobes - s0), 32'(SPF));
    check("frame_locked", 32'(locked), 32'd1);
    check("frame_queue_drained", 32'(exp_q.size()), 32'd0);

    // Sync on the second nibble of sample 5.
    for (int k = 0; k < 5; k++) begin
      exp_q.push_back('{8'(k), samp_val(k)});
      send_sample(samp_val(k), k == 0, 1);
    end
    send(samp_val(5)[11:8], 1'b0, 0);
    send(4'h9, 1'b1, 0);
    check("misalign_cnt", 32'(err_misalign_cnt), 32'd1);
    check("misalign_short_cnt", 32'(err_short_cnt), 32'd0);
    check("misalign_locked", 32'(locked), 32'd0);
    exp_q.push_back('{8'd0, 12'h9DE});
    send(4'hD, 1'b0, 0);
    send(4'hE, 1'b0, 0);
    tick();

    // Sync on a sample boundary after 100 samples.
    for (int k = 1; k < 100; k++) begin
      exp_q.push_back('{8'(k), samp_val(k)});
      send_sample(samp_val(k), 1'b0, 1);
    end
    send(4'h5, 1'b1, 0);
    check("short_cnt", 32'(err_short_cnt), 32'd1);
    check("short_misalign_cnt", 32'(err_misalign_cnt), 32'd1);
    exp_q.push_back('{8'd0, 12'h567});
    send(4'h6, 1'b0, 0);
    send(4'h7, 1'b0, 1);
    tick();
    check("short_queue_drained", 32'(exp_q.size()), 32'd0);

    // Disable mid-sample, unsynced nibbles, disable on a completing nibble.
    s0 = n_strobes;
    send(4'h1, 1'b0, 0);
    send(4'h2, 1'b0, 0);
    enable = 1'b0;
    tick();
    tick();
    check("disable_locked", 32'(locked), 32'd0);
    check("disable_keeps_misalign", 32'(err_misalign_cnt), 32'd1);
    check("disable_keeps_short", 32'(err_short_cnt), 32'd1);
    enable = 1'b1;
    tick();
    for (int i = 0; i < 6; i++) send(4'(i + 3), 1'b0, 0);
    send(4'hA, 1'b1, 0);
    send(4'hB, 1'b0, 0);
    nib_in = 4'hC; nib_valid = 1'b1; enable = 1'b0;
    tick();
    nib_valid = 1'b0; enable = 1'b1;
    tick();
    tick();
    check("nosync_strobe_count", 32'(n_strobes - s0), 32'd0);
    check("nosync_locked", 32'(locked), 32'd0);

    // Saturation and clear priority.
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("clr_misalign", 32'(err_misalign_cnt), 32'd0);
    check("clr_short", 32'(err_short_cnt), 32'd0);
    check("clr_sat_misalign", 32'(s2_err_misalign_cnt), 32'd0);
    send(4'h0, 1'b1, 0);
    for (int i = 0; i < 5; i++) send(4'(i + 1), 1'b1, 0);
    check("sat_misalign", 32'(s2_err_misalign_cnt), 32'd3);
    check("wide_misalign", 32'(err_misalign_cnt), 32'd5);
    check("sat_short", 32'(s2_err_short_cnt), 32'd0);
    err_clr = 1'b1;
    send(4'h7, 1'b1, 0);
    err_clr = 1'b0;
    check("clr_prio_sat", 32'(s2_err_misalign_cnt), 32'd0);
    check("clr_prio_wide", 32'(err_misalign_cnt), 32'd0);
    tick();
    check("final_queue_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
